// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg: shared types, MMIO map and byte-enable helper for dmem_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_RAM    = 3'd0,
    SEL_DUTY   = 3'd1,
    SEL_MILLIS = 3'd2,
    SEL_MICROS = 3'd3,
    SEL_NONE   = 3'd4
  } region_t;

  localparam logic [31:0] DUTY_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4;

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_B, F3_BU: byte_enables = 4'b0001 << lane;
      F3_H, F3_HU: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      default:     byte_enables = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bram.sv
// ---------------------------------------------------------------------------
// dmem_bram: word RAM with byte enables, 1-cycle synchronous read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_bram #(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder: data-memory target serving RAM, PWM duty register and timers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          CLK_HZ    = 12_000_000,
  parameter logic [31:0] RAM_BASE  = 32'h2000,
  parameter int          RAM_WORDS = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int          US_DIV  = CLK_HZ / 1_000_000;
  localparam int          PRE_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int          AW      = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;

  state_t         state, state_next;

  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata, r_mmio;
  logic [3:0]     r_be;
  logic [2:0]     r_f3;
  logic [1:0]     r_lane;
  logic           r_wren, r_err;
  region_t        r_sel;

  logic [31:0]    r_duty, r_millis, r_micros;
  logic [PRE_W-1:0] r_us_pre;
  logic [9:0]     r_ms_pre;
  logic [7:0]     r_pwm_cnt;

  region_t        w_sel;
  logic           w_misaligned, w_illegal, w_err, w_accept;
  logic [31:0]    w_lanes, w_mmio, w_word, w_shift, w_load;
  logic           ram_en;
  logic [3:0]     ram_we;
  logic [31:0]    ram_q;

  assign w_accept = req_valid && (state == S_IDLE);

  // Request decode; MMIO registers match on word address so sub-word access works
  always_comb begin
    w_sel = SEL_NONE;
    if ({1'b0, req_addr} >= {1'b0, RAM_BASE} && {1'b0, req_addr} < RAM_END)
      w_sel = SEL_RAM;
    else if (req_addr[31:2] == DUTY_ADDR[31:2])
      w_sel = SEL_DUTY;
    else if (req_addr[31:2] == MILLIS_ADDR[31:2])
      w_sel = SEL_MILLIS;
    else if (req_addr[31:2] == MICROS_ADDR[31:2])
      w_sel = SEL_MICROS;

    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    w_lanes      = req_wdata;
    case (req_funct3)
      F3_B:        w_lanes = {4{req_wdata[7:0]}};
      F3_H:        begin w_misaligned = req_addr[0]; w_lanes = {2{req_wdata[15:0]}}; end
      F3_W:        w_misaligned = |req_addr[1:0];
      F3_BU:       w_illegal = req_wren;
      F3_HU:       begin w_misaligned = req_addr[0]; w_illegal = req_wren; end
      default:     w_illegal = 1'b1;
    endcase

    w_err = w_illegal || w_misaligned || (w_sel == SEL_NONE) ||
            (req_wren && (w_sel == SEL_MILLIS || w_sel == SEL_MICROS));

    case (w_sel)
      SEL_DUTY:   w_mmio = r_duty;
      SEL_MILLIS: w_mmio = r_millis;
      SEL_MICROS: w_mmio = r_micros;
      default:    w_mmio = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wren  <= req_wren;
      r_f3    <= req_funct3;
      r_lane  <= req_addr[1:0];
      r_be    <= byte_enables(req_funct3, req_addr[1:0]);
      r_wdata <= w_lanes;
      r_idx   <= AW'((req_addr - RAM_BASE) >> 2);
      r_sel   <= w_sel;
      r_err   <= w_err;
      r_mmio  <= w_mmio;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = w_err ? S_RESP : (req_wren ? S_STORE : S_LOAD);
      S_LOAD:  state_next = S_RESP;
      S_STORE: state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Load path: RAM data comes straight from the BRAM register, which holds while in RESP
  always_comb begin
    w_word  = (r_sel == SEL_RAM) ? ram_q : r_mmio;
    w_shift = w_word >> {r_lane, 3'b000};
    case (r_f3)
      F3_B:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_BU:   w_load = {24'd0, w_shift[7:0]};
      F3_H:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_HU:   w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_err   = resp_valid && r_err;
    resp_rdata = (resp_valid && !r_err && !r_wren) ? w_load : 32'd0;
    ram_en     = (state == S_LOAD || state == S_STORE) && (r_sel == SEL_RAM);
    ram_we     = (state == S_STORE && r_sel == SEL_RAM) ? r_be : 4'd0;
  end

  dmem_bram #(
    .WORDS     (RAM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (r_idx),
    .wdata (r_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty <= 32'd0;
    end else if (state == S_STORE && r_sel == SEL_DUTY) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_duty[8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  // Free-running PWM counter and cascaded microsecond/millisecond timers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= 8'd0;
      led       <= 1'b0;
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
      r_us_pre  <= '0;
      r_ms_pre  <= 10'd0;
      r_micros  <= 32'd0;
      r_millis  <= 32'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      led       <= r_pwm_cnt < r_duty[7:0];
      red       <= r_pwm_cnt < r_duty[15:8];
      green     <= r_pwm_cnt < r_duty[23:16];
      blue      <= r_pwm_cnt < r_duty[31:24];
      if (r_us_pre == PRE_W'(US_DIV - 1)) begin
        r_us_pre <= '0;
        r_micros <= r_micros + 32'd1;
        if (r_ms_pre == 10'd999) begin
          r_ms_pre <= 10'd0;
          r_millis <= r_millis + 32'd1;
        end else begin
          r_ms_pre <= r_ms_pre + 10'd1;
        end
      end else begin
        r_us_pre <= r_us_pre + PRE_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder: randomized and directed checks against a byte-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int          CLK_HZ    = 2_000_000;
  localparam int          US_DIV    = CLK_HZ / 1_000_000;
  localparam logic [31:0] RAM_BASE  = 32'h2000;
  localparam int          RAM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_wren, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        led, red, green, blue;

  always #5 clk = ~clk;

  dmem_responder #(
    .CLK_HZ    (CLK_HZ),
    .RAM_BASE  (RAM_BASE),
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wren   (req_wren),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .led        (led),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  int checks = 0;
  int errors = 0;

  // Clock edges since reset was last released: the timers are pure functions of this
  int unsigned cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [7:0] mem_m  [RAM_WORDS*4];
  logic [7:0] duty_m [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 RAM, 1 duty, 2 millis, 3 micros, 4 unmapped
  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a >= RAM_BASE && a < RAM_BASE + 4*RAM_WORDS) return 0;
    if (w == 32'hFFFF_FFFC) return 1;
    if (w == 32'hFFFF_FFF8) return 2;
    if (w == 32'hFFFF_FFF4) return 3;
    return 4;
  endfunction

  function automatic int access_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // One full transaction; entered and left just after a falling edge
  task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] got, output logic got_err);
    int          rg, sz, lat, off;
    logic        legal, e;
    logic [31:0] word, exp_d;
    logic [31:0] held_d;
    logic        held_e;

    rg    = region(a);
    sz    = access_size(f3);
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) &&
            !(wr && f3[2]);
    e     = !legal || (a % sz) != 0 || rg == 4 || (wr && (rg == 2 || rg == 3));
    exp_d = 32'd0;
    if (!e && !wr) begin
      case (rg)
        0: begin
          off  = int'((a - RAM_BASE) & 32'hFFFF_FFFC);
          word = {mem_m[off+3], mem_m[off+2], mem_m[off+1], mem_m[off]};
        end
        1:       word = {duty_m[3], duty_m[2], duty_m[1], duty_m[0]};
        2:       word = cyc / (US_DIV * 1000);
        default: word = cyc / US_DIV;
      endcase
      exp_d = extend(word >> (8 * (a % 4)), f3);
    end
    if (!e && wr) begin
      for (int i = 0; i < sz; i++) begin
        if (rg == 0) mem_m[int'(a - RAM_BASE) + i] = wd[8*i +: 8];
        else         duty_m[(a % 4) + i] = wd[8*i +: 8];
      end
    end

    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wren   = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e ? 32'd1 : 32'd2);
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    check("resp_err", {31'd0, resp_err}, {31'd0, e});
    check("resp_rdata", resp_rdata, exp_d);
    got     = resp_rdata;
    got_err = resp_err;
    held_d  = resp_rdata;
    held_e  = resp_err;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, held_d);
      check("hold_err", {31'd0, resp_err}, {31'd0, held_e});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("consumed", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) duty_m[i] = 8'd0;
  endtask

  logic [31:0] got;
  logic        gerr;
  int          cnt_l, cnt_r, cnt_g, cnt_b;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wren   = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_pwm", {28'd0, led, red, green, blue}, 32'd0);
    do_reset();

    // Clear the RAM window the random phase uses
    for (int w = 0; w < 16; w++) xact(1'b1, 3'd2, RAM_BASE + 4*w, 32'd0, 0, got, gerr);
    for (int w = RAM_WORDS-4; w < RAM_WORDS; w++) xact(1'b1, 3'd2, RAM_BASE + 4*w, 32'd0, 0, got, gerr);

    xact(1'b1, 3'd2, 32'h2000, 32'hDEADBEEF, 0, got, gerr);
    xact(1'b0, 3'd2, 32'h2000, 32'd0, 0, got, gerr);
    check("t1_lw", got, 32'hDEADBEEF);

    xact(1'b1, 3'd2, 32'h2000, 32'd0, 0, got, gerr);
    xact(1'b1, 3'd0, 32'h2003, 32'h0000_0080, 0, got, gerr);
    xact(1'b0, 3'd0, 32'h2003, 32'd0, 0, got, gerr);
    check("t2_lb", got, 32'hFFFFFF80);
    xact(1'b0, 3'd4, 32'h2003, 32'd0, 0, got, gerr);
    check("t2_lbu", got, 32'h00000080);
    xact(1'b0, 3'd2, 32'h2000, 32'd0, 0, got, gerr);
    check("t2_lw", got, 32'h80000000);
    xact(1'b1, 3'd1, 32'h2002, 32'h0000_1234, 0, got, gerr);
    xact(1'b0, 3'd5, 32'h2002, 32'd0, 0, got, gerr);
    check("t2_lhu", got, 32'h00001234);

    xact(1'b0, 3'd2, 32'h2002, 32'd0, 0, got, gerr);
    check("t3_lw_misal", {31'd0, gerr}, 32'd1);
    xact(1'b1, 3'd1, 32'h2001, 32'hFFFFFFFF, 0, got, gerr);
    check("t3_sh_misal", {31'd0, gerr}, 32'd1);
    xact(1'b0, 3'd2, 32'h0000, 32'd0, 0, got, gerr);
    check("t3_unmapped", {31'd0, gerr}, 32'd1);
    xact(1'b1, 3'd3, 32'h2000, 32'hFFFFFFFF, 0, got, gerr);
    check("t3_f3_011", {31'd0, gerr}, 32'd1);
    xact(1'b0, 3'd2, 32'h2000, 32'd0, 0, got, gerr);
    check("t3_ram_kept", got, 32'h12340000);

    xact(1'b1, 3'd2, 32'hFFFFFFFC, 32'h00FF0080, 0, got, gerr);
    repeat (3) @(negedge clk);
    cnt_l = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      cnt_l += int'(led); cnt_r += int'(red); cnt_g += int'(green); cnt_b += int'(blue);
      @(negedge clk);
    end
    check("t4_led", cnt_l, 32'd128);
    check("t4_red", cnt_r, 32'd0);
    check("t4_green", cnt_g, 32'd255);
    check("t4_blue", cnt_b, 32'd0);
    xact(1'b0, 3'd2, 32'hFFFFFFFC, 32'd0, 0, got, gerr);
    check("t4_duty_rb", got, 32'h00FF0080);
    xact(1'b1, 3'd2, 32'hFFFFFFF8, 32'h1, 0, got, gerr);
    check("t4_ro_store", {31'd0, gerr}, 32'd1);

    xact(1'b0, 3'd2, 32'h2000, 32'd0, 5, got, gerr);

    // Reset while the load is in flight
    req_valid  = 1'b1;
    req_wren   = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) duty_m[i] = 8'd0;
    check("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("t6_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("t6_pwm_off", {28'd0, led, red, green, blue}, 32'd0);
    xact(1'b0, 3'd2, 32'hFFFFFFFC, 32'd0, 0, got, gerr);
    check("t6_duty_zero", got, 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 6)
        a = RAM_BASE + 4 * (($urandom % 2) ? ($urandom % 16) : (RAM_WORDS - 4 + $urandom % 4));
      else if (pick == 6) a = 32'hFFFFFFFC;
      else if (pick == 7) a = 32'hFFFFFFF8;
      else if (pick == 8) a = 32'hFFFFFFF4;
      else begin
        case ($urandom % 4)
          0:       a = 32'h0;
          1:       a = RAM_BASE - 4;
          2:       a = RAM_BASE + 4*RAM_WORDS;
          default: a = 32'hFFFFFFF0;
        endcase
      end
      a = a + ($urandom % 4);
      xact(1'(($urandom % 2)), 3'($urandom % 8), a, $urandom, $urandom_range(0, 3), got, gerr);
    end

    do_reset();
    while (cyc < 4000) @(negedge clk);
    xact(1'b0, 3'd2, 32'hFFFFFFF4, 32'd0, 0, got, gerr);
    check("t5_micros", got, 32'd2000);
    xact(1'b0, 3'd2, 32'hFFFFFFF8, 32'd0, 0, got, gerr);
    check("t5_millis", got, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
